sudoku_entry_ctrl: RTL and testbench
====================================

// Module: sudoku_entry_ctrl
// PURPOSE
//  Upstream of Sudoku_Solver. Turns one-pulse nav/enter buttons and PS/2-decoded digit keys into a
//  cursor (row,col), a staged digit and a single-cycle write strobe (read, data) on the solver's load port.
//  Writes to given (non-blank) cells are refused. A post-write holdoff throttles back-to-back writes.
//  row/col also drive the VGA cursor highlight.
// PARAMETERS
//  HOLDOFF_CYC   16  cycles after a write strobe during which enter/key/move are ignored (>=1)
//  AUTO_ADVANCE  1   1: after an accepted write, cursor steps to next cell (raster order); 0: cursor stays
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  mv_up         in   1   one-cycle pulse: cursor row-1
//  mv_down       in   1   one-cycle pulse: cursor row+1
//  mv_left       in   1   one-cycle pulse: cursor col-1
//  mv_right      in   1   one-cycle pulse: cursor col+1
//  enter         in   1   one-cycle pulse: commit staged digit
//  key_valid     in   1   one-cycle pulse: key_digit is valid
//  key_digit     in   4   0 = clear cell, 1..9 = digit; 10..15 ignored
//  board_blank   in   81  bit r*9+c = 1 -> cell editable
//  row           out  4   cursor row 0..8
//  col           out  4   cursor col 0..8
//  data          out  4   digit for solver; valid while read=1, held afterwards
//  read          out  1   one-cycle write strobe to solver
//  staged        out  1   a digit is staged
//  staged_digit  out  4   staged value (for display)
//  reject        out  1   one-cycle pulse: enter on a given cell
// BEHAVIOUR
//  Reset: row=0, col=0, data=0, read=0, staged=0, staged_digit=0, reject=0, FSM=IDLE, holdoff cnt=0.
//  FSM: IDLE (nothing staged), STAGED, WRITE (1 cycle), HOLD (HOLDOFF_CYC cycles).
//  IDLE:   key_valid & key_digit<=9 -> staged_digit<=key_digit, staged<=1, ->STAGED. enter ignored.
//  STAGED: key_valid & key_digit<=9 -> overwrite staged_digit (stay).
//          enter & board_blank[row*9+col] -> ->WRITE.
//          enter & !board_blank[...] -> reject=1 next cycle, staged<=0, ->IDLE.
//  WRITE:  read=1, data=staged_digit, row/col unchanged this cycle; staged<=0; cnt<=HOLDOFF_CYC-1; ->HOLD.
//          Following cycle: if AUTO_ADVANCE, col+1; col 8 -> col 0 with row+1; (8,8) -> (0,0).
//  HOLD:   cnt decrements each cycle; enter/key/move all dropped; cnt==0 -> IDLE.
//  Moves (IDLE/STAGED only): wrap per axis, no carry: col 8 +right -> 0, col 0 +left -> 8;
//    same for rows. Staged digit retained across moves.
//  Same-cycle priority: enter > key_valid > moves. Lower-priority events that cycle are dropped.
//    Conflicting moves (up+down or left+right) cancel on that axis; one row + one col move both apply.
//  Index arithmetic: idx = row*9+col in 7 bits, range 0..80; row/col never exceed 8.
//  Latency: enter -> read asserted exactly 1 cycle later (from WRITE state); reject likewise 1 cycle.
//  read and reject are never high together; each is high for at most 1 cycle per enter.
//  rst in any state (incl. WRITE/HOLD) -> reset values next cycle; in-flight write not emitted.
// TESTING
//  1 Reset, then 9x mv_right -> col sequence 1..8,0; row stays 0. mv_up at row 0 -> row 8.
//  2 Cursor (2,3), bit 21 of board_blank = 1, key 7 then enter -> one read pulse, data=7, row=2, col=3;
//    AUTO_ADVANCE=1 -> cursor (2,4).
//  3 Cursor (4,4), bit 40 = 0, key 5, enter -> reject one cycle, read stays 0, staged=0.
//  4 After write, enter + key 3 during holdoff (HOLDOFF_CYC=16) -> no read; the same inputs at cycle 17 -> honored.
//  5 Cursor (8,8), AUTO_ADVANCE=1, write 9 -> cursor (0,0). key 12 -> no state change.
//  6 enter and mv_right in the same cycle while STAGED at (1,1) -> write at (1,1), move dropped; rst during HOLD -> all outputs return to reset values.

Source files
------------

// File: rtl/sudoku_entry_ctrl_if.sv
// ---------------------------------------------------------------------------
// sudoku_entry_ctrl_if
// Groups the entry controller's input events and its solver/VGA-facing outputs.
//   master : the upstream side (buttons, PS/2 digit decoder, board blank map).
//            It drives the events and observes the cursor and write port.
//   slave  : the entry controller. It consumes the events and drives the
//            cursor, the staged digit and the solver load port.
// Signals
//   mv_up/mv_down/mv_left/mv_right  one-cycle cursor move pulses
//   enter                           one-cycle commit pulse
//   key_valid, key_digit[3:0]       digit key event (0 clears, 1..9 digit)
//   board_blank[80:0]               bit r*9+c set -> cell is editable
//   row/col[3:0]                    cursor position 0..8
//   data[3:0], read                 solver load port (read = write strobe)
//   staged, staged_digit[3:0]       staged digit for display
//   reject                          enter refused on a given cell
// ---------------------------------------------------------------------------
interface sudoku_entry_ctrl_if;
  logic        mv_up;
  logic        mv_down;
  logic        mv_left;
  logic        mv_right;
  logic        enter;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic [80:0] board_blank;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  data;
  logic        read;
  logic        staged;
  logic [3:0]  staged_digit;
  logic        reject;

  modport master (
    output mv_up, mv_down, mv_left, mv_right, enter, key_valid, key_digit, board_blank,
    input  row, col, data, read, staged, staged_digit, reject
  );

  modport slave (
    input  mv_up, mv_down, mv_left, mv_right, enter, key_valid, key_digit, board_blank,
    output row, col, data, read, staged, staged_digit, reject
  );
endinterface

// File: rtl/sudoku_entry_ctrl.sv
// ---------------------------------------------------------------------------
// sudoku_entry_ctrl
// Front end for the Sudoku solver's load port. Button pulses move a cursor
// over the 9x9 board, PS/2 digit keys stage a value, and enter commits it as
// a single-cycle write strobe. Given (non-blank) cells refuse the write with a
// one-cycle reject pulse. After each write a holdoff window ignores all input.
// Parameters
//   HOLDOFF_CYC   cycles after the write strobe during which input is dropped
//   AUTO_ADVANCE  1: cursor steps to the next cell in raster order after a write
// Ports
//   clk     system clock
//   rst     synchronous active-high reset
//   bus_io  slave side of sudoku_entry_ctrl_if (events in, cursor/port out)
// ---------------------------------------------------------------------------
module sudoku_entry_ctrl #(
  parameter int unsigned HOLDOFF_CYC  = 16,
  parameter bit          AUTO_ADVANCE = 1'b1
) (
  input logic                clk,
  input logic                rst,
  sudoku_entry_ctrl_if.slave bus_io
);

  // Counter holds HOLDOFF_CYC-1 down to 0, so clog2 bits suffice (min 1).
  localparam int unsigned CntW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLDOFF_CYC - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStaged = 2'd1;
  localparam logic [1:0] StWrite  = 2'd2;
  localparam logic [1:0] StHold   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      row_q, row_d;
  logic [3:0]      col_q, col_d;
  logic [3:0]      data_q, data_d;
  logic            staged_q, staged_d;
  logic [3:0]      sdig_q, sdig_d;
  logic            reject_q, reject_d;

  logic       key_ok;
  logic [6:0] idx;
  logic       cell_blank;
  logic [3:0] row_step, col_step;
  logic [3:0] row_adv, col_adv;

  // Keys 10..15 are not events at all; they neither stage nor mask moves.
  assign key_ok     = bus_io.key_valid && (bus_io.key_digit <= 4'd9);
  assign idx        = 7'(row_q) * 7'd9 + 7'(col_q);
  assign cell_blank = bus_io.board_blank[idx];

  // Per-axis wrapping moves; opposing pulses on one axis cancel.
  always_comb begin
    row_step = row_q;
    if (bus_io.mv_up && !bus_io.mv_down) begin
      row_step = (row_q == 4'd0) ? 4'd8 : row_q - 4'd1;
    end else if (bus_io.mv_down && !bus_io.mv_up) begin
      row_step = (row_q == 4'd8) ? 4'd0 : row_q + 4'd1;
    end
  end

  always_comb begin
    col_step = col_q;
    if (bus_io.mv_left && !bus_io.mv_right) begin
      col_step = (col_q == 4'd0) ? 4'd8 : col_q - 4'd1;
    end else if (bus_io.mv_right && !bus_io.mv_left) begin
      col_step = (col_q == 4'd8) ? 4'd0 : col_q + 4'd1;
    end
  end

  // Raster-order advance with carry into the row; (8,8) wraps to (0,0).
  always_comb begin
    row_adv = row_q;
    col_adv = col_q + 4'd1;
    if (col_q == 4'd8) begin
      col_adv = 4'd0;
      row_adv = (row_q == 4'd8) ? 4'd0 : row_q + 4'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    data_d   = data_q;
    staged_d = staged_q;
    sdig_d   = sdig_q;
    reject_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // enter has nothing to commit here, so it does not mask key or moves.
        if (key_ok) begin
          sdig_d   = bus_io.key_digit;
          staged_d = 1'b1;
          state_d  = StStaged;
        end else begin
          row_d = row_step;
          col_d = col_step;
        end
      end

      StStaged: begin
        if (bus_io.enter) begin
          if (cell_blank) begin
            data_d  = sdig_q;
            state_d = StWrite;
          end else begin
            reject_d = 1'b1;
            staged_d = 1'b0;
            state_d  = StIdle;
          end
        end else if (key_ok) begin
          sdig_d = bus_io.key_digit;
        end else begin
          row_d = row_step;
          col_d = col_step;
        end
      end

      StWrite: begin
        // Cursor still points at the written cell during the strobe.
        staged_d = 1'b0;
        cnt_d    = CntLoad;
        state_d  = StHold;
        if (AUTO_ADVANCE) begin
          row_d = row_adv;
          col_d = col_adv;
        end
      end

      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      row_q    <= 4'd0;
      col_q    <= 4'd0;
      data_q   <= 4'd0;
      staged_q <= 1'b0;
      sdig_q   <= 4'd0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      data_q   <= data_d;
      staged_q <= staged_d;
      sdig_q   <= sdig_d;
      reject_q <= reject_d;
    end
  end

  assign bus_io.row          = row_q;
  assign bus_io.col          = col_q;
  assign bus_io.data         = data_q;
  assign bus_io.read         = (state_q == StWrite);
  assign bus_io.staged       = staged_q;
  assign bus_io.staged_digit = sdig_q;
  assign bus_io.reject       = reject_q;

endmodule

// File: tb/tb_sudoku_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sudoku_entry_ctrl
// Directed scenarios with literal expectations, then randomized events, all
// compared every cycle against a behavioural model of the entry controller.
// ---------------------------------------------------------------------------
module tb_sudoku_entry_ctrl;

  localparam int unsigned Holdoff = 16;
  localparam bit          AutoAdv = 1'b1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  bit   cmp_en;

  sudoku_entry_ctrl_if bus ();

  sudoku_entry_ctrl #(
    .HOLDOFF_CYC  (Holdoff),
    .AUTO_ADVANCE (AutoAdv)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: cursor as integers, holdoff as a remaining-cycle count.
  int m_row, m_col, m_data, m_sdig, m_hold;
  bit m_staged, m_read, m_reject;

  initial begin
    m_row = 0; m_col = 0; m_data = 0; m_sdig = 0; m_hold = 0;
    m_staged = 0; m_read = 0; m_reject = 0;
  end

  always @(posedge clk) begin
    int lin;
    int dr;
    int dc;
    bit nr;
    bit nj;
    nr = 0;
    nj = 0;
    if (rst) begin
      m_row = 0; m_col = 0; m_data = 0; m_sdig = 0; m_hold = 0;
      m_staged = 0; m_read = 0; m_reject = 0;
    end else begin
      if (m_read) begin
        m_staged = 0;
        if (AutoAdv) begin
          lin   = (m_row * 9 + m_col + 1) % 81;
          m_row = lin / 9;
          m_col = lin % 9;
        end
        m_hold = Holdoff;
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end else if (bus.enter && m_staged) begin
        if (bus.board_blank[m_row * 9 + m_col]) begin
          nr     = 1;
          m_data = m_sdig;
        end else begin
          nj       = 1;
          m_staged = 0;
        end
      end else if (bus.key_valid && bus.key_digit <= 4'd9) begin
        m_sdig   = int'(bus.key_digit);
        m_staged = 1;
      end else begin
        dr    = int'(bus.mv_down) - int'(bus.mv_up);
        dc    = int'(bus.mv_right) - int'(bus.mv_left);
        m_row = (m_row + dr + 9) % 9;
        m_col = (m_col + dc + 9) % 9;
      end
      m_read   = nr;
      m_reject = nj;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("row", 32'(bus.row), m_row);
      chk("col", 32'(bus.col), m_col);
      chk("data", 32'(bus.data), m_data);
      chk("read", 32'(bus.read), 32'(m_read));
      chk("staged", 32'(bus.staged), 32'(m_staged));
      chk("staged_digit", 32'(bus.staged_digit), m_sdig);
      chk("reject", 32'(bus.reject), 32'(m_reject));
      chk("read_reject_excl", 32'(bus.read & bus.reject), 0);
    end
  end

  task automatic clear_in();
    bus.mv_up = 0; bus.mv_down = 0; bus.mv_left = 0; bus.mv_right = 0;
    bus.enter = 0; bus.key_valid = 0; bus.key_digit = 4'd0;
  endtask

  // Drive one cycle of events starting at a negedge; return at the next negedge.
  task automatic step(input bit up, input bit dn, input bit lf, input bit rt,
                      input bit ent, input bit kv, input logic [3:0] kd);
    bus.mv_up = up; bus.mv_down = dn; bus.mv_left = lf; bus.mv_right = rt;
    bus.enter = ent; bus.key_valid = kv; bus.key_digit = kd;
    @(negedge clk);
    clear_in();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    step(0, 0, 0, 0, 0, 1, d);
  endtask

  task automatic press_enter();
    step(0, 0, 0, 0, 1, 0, 4'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row"}, 32'(bus.row), 0);
    chk({tag, "_col"}, 32'(bus.col), 0);
    chk({tag, "_data"}, 32'(bus.data), 0);
    chk({tag, "_read"}, 32'(bus.read), 0);
    chk({tag, "_staged"}, 32'(bus.staged), 0);
    chk({tag, "_sdig"}, 32'(bus.staged_digit), 0);
    chk({tag, "_reject"}, 32'(bus.reject), 0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    cmp_en   = 0;
    rst      = 1;
    clear_in();
    // Every cell editable except (4,4).
    bus.board_blank = '1;
    bus.board_blank[40] = 1'b0;
    @(negedge clk);
    cmp_en = 1;
    @(negedge clk);
    rst = 0;
    chk_reset_vals("t0");

    // 1: column wrap via right moves, row wrap via up.
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 1, 0, 0, 4'd0);
      chk("t1_col", 32'(bus.col), (i + 1) % 9);
      chk("t1_row", 32'(bus.row), 0);
    end
    step(1, 0, 0, 0, 0, 0, 4'd0);
    chk("t1_row_wrap", 32'(bus.row), 8);
    step(0, 1, 0, 0, 0, 0, 4'd0);
    chk("t1_row_back", 32'(bus.row), 0);

    // 2: write 7 at (2,3), cursor advances to (2,4).
    step(0, 1, 0, 0, 0, 0, 4'd0);
    step(0, 1, 0, 0, 0, 0, 4'd0);
    repeat (3) step(0, 0, 0, 1, 0, 0, 4'd0);
    key(4'd7);
    chk("t2_staged", 32'(bus.staged), 1);
    chk("t2_sdig", 32'(bus.staged_digit), 7);
    press_enter();
    chk("t2_read", 32'(bus.read), 1);
    chk("t2_data", 32'(bus.data), 7);
    chk("t2_row", 32'(bus.row), 2);
    chk("t2_col", 32'(bus.col), 3);
    idle(1);
    chk("t2_read_off", 32'(bus.read), 0);
    chk("t2_adv_col", 32'(bus.col), 4);
    chk("t2_unstaged", 32'(bus.staged), 0);

    // 4: enter+key during the holdoff window are dropped, honored after it.
    for (int i = 0; i < int'(Holdoff); i++) begin
      step(0, 0, 0, 0, 1, 1, 4'd3);
      chk("t4_hold_read", 32'(bus.read), 0);
      chk("t4_hold_staged", 32'(bus.staged), 0);
    end
    step(0, 0, 0, 0, 1, 1, 4'd3);
    chk("t4_after_staged", 32'(bus.staged), 1);
    chk("t4_after_sdig", 32'(bus.staged_digit), 3);
    press_enter();
    chk("t4_after_read", 32'(bus.read), 1);
    chk("t4_after_data", 32'(bus.data), 3);
    idle(1 + int'(Holdoff));

    // 3: refused write on given cell (4,4).
    step(0, 1, 0, 0, 0, 0, 4'd0);
    step(0, 1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 0, 0, 4'd0);
    chk("t3_row", 32'(bus.row), 4);
    chk("t3_col", 32'(bus.col), 4);
    key(4'd5);
    press_enter();
    chk("t3_reject", 32'(bus.reject), 1);
    chk("t3_read", 32'(bus.read), 0);
    chk("t3_staged", 32'(bus.staged), 0);
    idle(1);
    chk("t3_reject_off", 32'(bus.reject), 0);

    // 5: write at (8,8) wraps to (0,0); key 12 is ignored.
    repeat (4) step(0, 1, 0, 0, 0, 0, 4'd0);
    repeat (4) step(0, 0, 0, 1, 0, 0, 4'd0);
    key(4'd9);
    press_enter();
    chk("t5_read", 32'(bus.read), 1);
    chk("t5_data", 32'(bus.data), 9);
    idle(1);
    chk("t5_row", 32'(bus.row), 0);
    chk("t5_col", 32'(bus.col), 0);
    idle(int'(Holdoff));
    key(4'd12);
    chk("t5_k12_staged", 32'(bus.staged), 0);
    chk("t5_k12_sdig", 32'(bus.staged_digit), 9);

    // 6: enter beats a same-cycle move; reset during holdoff.
    step(0, 1, 0, 1, 0, 0, 4'd0);
    chk("t6_diag_row", 32'(bus.row), 1);
    chk("t6_diag_col", 32'(bus.col), 1);
    key(4'd4);
    step(0, 0, 0, 1, 1, 0, 4'd0);
    chk("t6_read", 32'(bus.read), 1);
    chk("t6_row", 32'(bus.row), 1);
    chk("t6_col", 32'(bus.col), 1);
    chk("t6_data", 32'(bus.data), 4);
    idle(3);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_reset_vals("t6_rst");
    idle(20);

    // Randomized events against the model.
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) begin
        bus.board_blank = {$urandom, $urandom, $urandom} | {$urandom, $urandom, $urandom};
      end
      bus.mv_up     = ($urandom_range(0, 5) == 0);
      bus.mv_down   = ($urandom_range(0, 5) == 0);
      bus.mv_left   = ($urandom_range(0, 5) == 0);
      bus.mv_right  = ($urandom_range(0, 5) == 0);
      bus.enter     = ($urandom_range(0, 7) == 0);
      bus.key_valid = ($urandom_range(0, 4) == 0);
      bus.key_digit = 4'($urandom_range(0, 15));
      rst           = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 0;
    clear_in();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
